// File: rtl/rssi_delay_seq_ctrl.sv
// Configuration sequencer for the RSSI path: defers updates past packet reception, flushes the
// delay FIFO, applies delay/offset atomically and reports when rssi_half_db is valid again.
// Optional WAIT_RX timeout is built when RSSI_SEQ_TIMEOUT_EN is defined.
module rssi_delay_seq_ctrl #(
  parameter int DELAY_CTL_WIDTH    = 7,
  parameter int RSSI_HALF_DB_WIDTH = 11,
  parameter int RST_PULSE_LEN      = 4,
  parameter logic [DELAY_CTL_WIDTH-1:0] RESET_DELAY_CTL = 7'd39
`ifdef RSSI_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES   = 20000
`endif
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DELAY_CTL_WIDTH-1:0]    cfg_delay_ctl_i,
  input  logic [RSSI_HALF_DB_WIDTH-1:0] cfg_rssi_half_db_offset_i,
  input  logic                          cfg_update_i,
  input  logic                          rx_busy_i,
  input  logic                          iq_rssi_half_db_valid_i,
  output logic [DELAY_CTL_WIDTH-1:0]    delay_ctl_o,
  output logic [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db_offset_o,
  output logic                          fifo_delay_rstn_o,
  output logic                          rssi_settled_o,
  output logic                          seq_busy_o,
  output logic                          update_done_o,
  output logic                          timeout_err_o
);

  localparam int CNT_WIDTH = DELAY_CTL_WIDTH + 1;
  localparam logic [3:0] FLUSH_LAST = 4'(RST_PULSE_LEN - 1);

  typedef enum logic [1:0] {IDLE, WAIT_RX, FLUSH, REFILL} state_t;

  state_t                         state_q;
  logic [3:0]                     flushCnt_q;
  logic [CNT_WIDTH-1:0]           refillCnt_q;
  logic [CNT_WIDTH-1:0]           refillNext_d;
  logic [CNT_WIDTH-1:0]           refillTarget_d;
  logic                           pending_q;
  logic [DELAY_CTL_WIDTH-1:0]     shadowDelay_q;
  logic [DELAY_CTL_WIDTH-1:0]     shadowDelay_d;
  logic [RSSI_HALF_DB_WIDTH-1:0]  shadowOffset_q;
  logic [RSSI_HALF_DB_WIDTH-1:0]  shadowOffset_d;
  logic                           goFlush_d;

  // A request arriving on the same edge that enters FLUSH must be the one applied.
  always_comb begin
    shadowDelay_d  = cfg_update_i ? cfg_delay_ctl_i : shadowDelay_q;
    shadowOffset_d = cfg_update_i ? cfg_rssi_half_db_offset_i : shadowOffset_q;
    refillNext_d   = refillCnt_q + CNT_WIDTH'(1);
    refillTarget_d = {1'b0, delay_ctl_o} + CNT_WIDTH'(1);
  end

`ifdef RSSI_SEQ_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] timeoutCnt_q;
  logic        timeoutHit_d;

  always_ff @(posedge clk) begin
    if (!rstn || state_q != WAIT_RX)
      timeoutCnt_q <= '0;
    else if (rx_busy_i)
      timeoutCnt_q <= timeoutCnt_q + 16'd1;
  end

  assign timeoutHit_d = rx_busy_i && (timeoutCnt_q == TIMEOUT_LAST);
  assign goFlush_d    = !rx_busy_i || timeoutHit_d;
`else
  assign goFlush_d     = !rx_busy_i;
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q               <= FLUSH;
      flushCnt_q            <= '0;
      refillCnt_q           <= '0;
      pending_q             <= 1'b0;
      shadowDelay_q         <= RESET_DELAY_CTL;
      shadowOffset_q        <= '0;
      delay_ctl_o           <= RESET_DELAY_CTL;
      rssi_half_db_offset_o <= '0;
      fifo_delay_rstn_o     <= 1'b0;
      rssi_settled_o        <= 1'b0;
      seq_busy_o            <= 1'b1;
      update_done_o         <= 1'b0;
`ifdef RSSI_SEQ_TIMEOUT_EN
      timeout_err_o         <= 1'b0;
`endif
    end else begin
      shadowDelay_q  <= shadowDelay_d;
      shadowOffset_q <= shadowOffset_d;
      update_done_o  <= 1'b0;
`ifdef RSSI_SEQ_TIMEOUT_EN
      timeout_err_o  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (cfg_update_i) begin
            state_q    <= WAIT_RX;
            seq_busy_o <= 1'b1;
          end
        end
        // Settings change on the same edge fifo_delay_rstn falls.
        WAIT_RX: begin
          if (goFlush_d) begin
            state_q               <= FLUSH;
            flushCnt_q            <= '0;
            pending_q             <= 1'b0;
            delay_ctl_o           <= shadowDelay_d;
            rssi_half_db_offset_o <= shadowOffset_d;
            fifo_delay_rstn_o     <= 1'b0;
            rssi_settled_o        <= 1'b0;
`ifdef RSSI_SEQ_TIMEOUT_EN
            timeout_err_o         <= timeoutHit_d;
`endif
          end
        end
        FLUSH: begin
          if (cfg_update_i)
            pending_q <= 1'b1;
          if (flushCnt_q == FLUSH_LAST) begin
            flushCnt_q        <= '0;
            fifo_delay_rstn_o <= 1'b1;
            if (pending_q || cfg_update_i) begin
              state_q   <= WAIT_RX;
              pending_q <= 1'b0;
            end else begin
              state_q     <= REFILL;
              refillCnt_q <= '0;
            end
          end else begin
            flushCnt_q <= flushCnt_q + 4'd1;
          end
        end
        REFILL: begin
          if (cfg_update_i) begin
            state_q     <= WAIT_RX;
            refillCnt_q <= '0;
          end else if (iq_rssi_half_db_valid_i) begin
            if (refillNext_d == refillTarget_d) begin
              state_q        <= IDLE;
              refillCnt_q    <= '0;
              rssi_settled_o <= 1'b1;
              update_done_o  <= 1'b1;
              seq_busy_o     <= 1'b0;
            end else begin
              refillCnt_q <= refillNext_d;
            end
          end
        end
        default: state_q <= FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_rssi_delay_seq_ctrl.sv
// Self-checking bench for rssi_delay_seq_ctrl: directed sequences with randomized settings,
// strobe spacing and rx_busy lengths, checked against expectations derived from the sequencing rules.
module tb_rssi_delay_seq_ctrl;

  localparam int RST_PULSE_LEN = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [6:0]  cfgDelay;
  logic [10:0] cfgOffset;
  logic        cfgUpdate;
  logic        rxBusy;
  logic        iqValid;
  logic [6:0]  delayCtl;
  logic [10:0] offsetOut;
  logic        fifoRstn;
  logic        settled;
  logic        seqBusy;
  logic        updateDone;
  logic        timeoutErr;

  int checks = 0;
  int errors = 0;
  logic [6:0]  modelDelay;
  logic [10:0] modelOffset;

  rssi_delay_seq_ctrl #(.RST_PULSE_LEN(RST_PULSE_LEN)) dut (
    .clk                       (clk),
    .rstn                      (rstn),
    .cfg_delay_ctl_i           (cfgDelay),
    .cfg_rssi_half_db_offset_i (cfgOffset),
    .cfg_update_i              (cfgUpdate),
    .rx_busy_i                 (rxBusy),
    .iq_rssi_half_db_valid_i   (iqValid),
    .delay_ctl_o               (delayCtl),
    .rssi_half_db_offset_o     (offsetOut),
    .fifo_delay_rstn_o         (fifoRstn),
    .rssi_settled_o            (settled),
    .seq_busy_o                (seqBusy),
    .update_done_o             (updateDone),
    .timeout_err_o             (timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_delay"}, delayCtl, 7'd39);
    checkOutput({tag, "_offset"}, offsetOut, 0);
    checkOutput({tag, "_fifo"}, fifoRstn, 0);
    checkOutput({tag, "_settled"}, settled, 0);
    checkOutput({tag, "_busy"}, seqBusy, 1);
    checkOutput({tag, "_done"}, updateDone, 0);
    checkOutput({tag, "_timeout"}, timeoutErr, 0);
  endtask

  // Request from IDLE with rx idle: WAIT_RX for one cycle, then FLUSH.
  task automatic startUpdate(input logic [6:0] d, input logic [10:0] o);
    cfgDelay = d; cfgOffset = o; cfgUpdate = 1'b1; rxBusy = 1'b0;
    applyStimulus();
    cfgUpdate = 1'b0;
    checkOutput("waitBusy", seqBusy, 1);
    checkOutput("waitSettled", settled, 1);
    checkOutput("waitFifo", fifoRstn, 1);
    checkOutput("waitOldDelay", delayCtl, modelDelay);
    applyStimulus();
    checkOutput("flushAfterTwo", fifoRstn, 0);
  endtask

  // Entered with the first FLUSH cycle observed; counts how long fifo_delay_rstn stays low.
  task automatic flushPhase(input logic [6:0] expD, input logic [10:0] expO, input bit midUpdate,
                            input logic [6:0] nd, input logic [10:0] no);
    int low = 0;
    modelDelay = expD; modelOffset = expO;
    checkOutput("flushDelay", delayCtl, expD);
    checkOutput("flushOffset", offsetOut, expO);
    checkOutput("flushSettled", settled, 0);
    checkOutput("flushBusy", seqBusy, 1);
    while (fifoRstn === 1'b0 && low < 50) begin
      iqValid = 1'($urandom_range(0, 1));
      if (midUpdate && low == 1) begin
        cfgUpdate = 1'b1; cfgDelay = nd; cfgOffset = no;
      end
      applyStimulus();
      low++;
      iqValid = 1'b0; cfgUpdate = 1'b0;
    end
    checkOutput("flushLen", low, RST_PULSE_LEN);
    checkOutput("flushHoldDelay", delayCtl, expD);
    if (midUpdate) begin
      checkOutput("pendSettled", settled, 0);
      checkOutput("pendBusy", seqBusy, 1);
    end
  endtask

  // Strobes every gap cycles; optional abort with a new request at strobe number abortAt.
  task automatic refillPhase(input int expD, input int gap, input int abortAt,
                             input logic [6:0] nd, input logic [10:0] no);
    int strobes = 0;
    int cyc = 0;
    int bound = (expD + 2) * gap + 20;
    bit fin = 0;
    bit abortNow;
    while (!fin && cyc < bound) begin
      iqValid = (cyc % gap == 0);
      if (iqValid) strobes++;
      abortNow = (abortAt > 0) && iqValid && (strobes == abortAt);
      if (abortNow) begin
        cfgUpdate = 1'b1; cfgDelay = nd; cfgOffset = no;
      end
      applyStimulus();
      cyc++;
      iqValid = 1'b0; cfgUpdate = 1'b0;
      if (abortNow) begin
        checkOutput("abortSettled", settled, 0);
        checkOutput("abortBusy", seqBusy, 1);
        checkOutput("abortDone", updateDone, 0);
        checkOutput("abortFifo", fifoRstn, 1);
        return;
      end
      if (updateDone === 1'b1) fin = 1;
      else checkOutput("refillSettled", settled, 0);
    end
    checkOutput("refillDone", fin, 1);
    checkOutput("refillStrobes", strobes, expD + 1);
    checkOutput("idleSettled", settled, 1);
    checkOutput("idleBusy", seqBusy, 0);
    checkOutput("idleFifo", fifoRstn, 1);
    applyStimulus();
    checkOutput("donePulse", updateDone, 0);
    checkOutput("idleHold", {delayCtl, settled}, {modelDelay, 1'b1});
  endtask

  initial begin
    logic [6:0]  d;
    logic [6:0]  d2;
    logic [10:0] o;
    logic [10:0] o2;
    rstn = 1'b0; cfgDelay = '0; cfgOffset = '0; cfgUpdate = 1'b0; rxBusy = 1'b0; iqValid = 1'b0;
    repeat (3) applyStimulus();
    checkResetState("reset");

    rstn = 1'b1;
    flushPhase(7'd39, 11'd0, 0, 7'd0, 11'd0);
    refillPhase(39, 4, 0, 7'd0, 11'd0);

    startUpdate(7'd16, 11'h1F0);
    flushPhase(7'd16, 11'h1F0, 0, 7'd0, 11'd0);
    refillPhase(16, $urandom_range(1, 3), 0, 7'd0, 11'd0);

    startUpdate(7'd0, 11'h7FF);
    flushPhase(7'd0, 11'h7FF, 0, 7'd0, 11'd0);
    refillPhase(0, 2, 0, 7'd0, 11'd0);

    startUpdate(7'd127, 11'h001);
    flushPhase(7'd127, 11'h001, 0, 7'd0, 11'd0);
    refillPhase(127, 1, 0, 7'd0, 11'd0);

    for (int i = 0; i < 4; i++) begin
      d = 7'($urandom_range(0, 127));
      o = 11'($urandom_range(0, 2047));
      startUpdate(d, o);
      flushPhase(d, o, 0, 7'd0, 11'd0);
      refillPhase(int'(d), $urandom_range(1, 3), 0, 7'd0, 11'd0);
    end

    // Request deferred by reception; the second write before rx ends wins.
    d  = 7'($urandom_range(0, 63));
    d2 = 7'($urandom_range(64, 127));
    o2 = 11'($urandom_range(0, 2047));
    rxBusy = 1'b1; cfgDelay = d; cfgUpdate = 1'b1;
    applyStimulus();
    cfgUpdate = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c == 150) begin
        cfgDelay = d2; cfgOffset = o2; cfgUpdate = 1'b1;
      end
      applyStimulus();
      cfgUpdate = 1'b0;
      checkOutput("rxHold", {delayCtl, settled, fifoRstn, timeoutErr}, {modelDelay, 3'b110});
    end
    rxBusy = 1'b0;
    applyStimulus();
    checkOutput("flushAfterRx", fifoRstn, 0);
    flushPhase(d2, o2, 0, 7'd0, 11'd0);
    refillPhase(int'(d2), 2, 0, 7'd0, 11'd0);

    // New request in the 5th REFILL strobe restarts the sequence.
    o  = 11'($urandom_range(0, 2047));
    o2 = 11'($urandom_range(0, 2047));
    startUpdate(7'd20, o);
    flushPhase(7'd20, o, 0, 7'd0, 11'd0);
    refillPhase(20, $urandom_range(1, 3), 5, 7'd8, o2);
    applyStimulus();
    checkOutput("reflush", fifoRstn, 0);
    flushPhase(7'd8, o2, 0, 7'd0, 11'd0);
    refillPhase(8, 3, 0, 7'd0, 11'd0);

    // Request during FLUSH: full pulse, then WAIT_RX and a second flush.
    o  = 11'($urandom_range(0, 2047));
    o2 = 11'($urandom_range(0, 2047));
    startUpdate(7'd50, o);
    flushPhase(7'd50, o, 1, 7'd70, o2);
    applyStimulus();
    checkOutput("pendFlush", fifoRstn, 0);
    flushPhase(7'd70, o2, 0, 7'd0, 11'd0);
    refillPhase(70, 1, 0, 7'd0, 11'd0);

    // Reset in mid-REFILL discards everything and replays the power-up sequence.
    startUpdate(7'd30, 11'h155);
    flushPhase(7'd30, 11'h155, 0, 7'd0, 11'd0);
    iqValid = 1'b1;
    repeat (10) applyStimulus();
    iqValid = 1'b0;
    checkOutput("midRefillSettled", settled, 0);
    rstn = 1'b0;
    applyStimulus();
    checkResetState("midReset");
    rstn = 1'b1;
    flushPhase(7'd39, 11'd0, 0, 7'd0, 11'd0);
    refillPhase(39, 2, 0, 7'd0, 11'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
